reorder_buffer_core: RTL

In-order reassembly stage for tagged, out-of-order responses. Issues sequential slot IDs to requesters, stores responses returning in any order, and releases them strictly in allocation order over a valid/ready interface. Sits directly upstream of the output double buffer and drives its up_valid/up_ready/up_data port.

---
 rtl/reorder_buffer_core.sv | 88 ++++++++
 1 files changed

// File: rtl/reorder_buffer_core.sv
// Reorder buffer: hands out sequential slot IDs, accepts tagged responses in any order,
// and releases payloads strictly in allocation order over a valid/ready port.
module reorder_buffer_core #(
    parameter int width = 8,
    parameter int depth = 4,
    localparam int id_width = $clog2(depth)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    output logic [id_width-1:0] alloc_id,
    input  logic                resp_valid,
    input  logic [id_width-1:0] resp_id,
    input  logic [width-1:0]    resp_data,
    output logic                down_valid,
    input  logic                down_ready,
    output logic [width-1:0]    down_data,
    output logic                err
);

    logic [id_width:0]   head;
    logic [id_width:0]   tail;
    logic [id_width:0]   count;
    logic [depth-1:0]    filled;
    logic [width-1:0]    data_mem [depth];

    logic [id_width-1:0] head_idx;
    logic [id_width-1:0] tail_idx;
    logic [id_width-1:0] resp_off;
    logic                empty;
    logic                full;
    logic                resp_legal;
    logic                alloc_fire;
    logic                pop_fire;
    logic                resp_write;

    always_comb begin
        head_idx   = head[id_width-1:0];
        tail_idx   = tail[id_width-1:0];
        count      = tail - head;
        empty      = (count == '0);
        full       = (count == (id_width+1)'(depth));
        resp_off   = resp_id - head_idx;
        // Offset from head must fall inside the allocated window and the slot must still be waiting.
        resp_legal = ({1'b0, resp_off} < count) && !filled[resp_id];
        alloc_fire = alloc_valid && !full;
        pop_fire   = down_valid && down_ready;
        resp_write = resp_valid && resp_legal;
    end

    assign alloc_ready = !full;
    assign alloc_id    = tail_idx;
    assign down_valid  = !empty && filled[head_idx];
    assign down_data   = down_valid ? data_mem[head_idx] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            filled <= '0;
            err    <= 1'b0;
        end else begin
            if (alloc_fire) begin
                tail             <= tail + 1'b1;
                filled[tail_idx] <= 1'b0;
            end
            if (pop_fire) begin
                head             <= head + 1'b1;
                filled[head_idx] <= 1'b0;
            end
            // A legal response can never target the head being popped or the slot being allocated.
            if (resp_write) begin
                filled[resp_id] <= 1'b1;
            end
            if (resp_valid && !resp_legal) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resp_write) begin
            data_mem[resp_id] <= resp_data;
        end
    end

endmodule
